// File: rtl/error_injector_multi.sv
// error_injector_multi: flips per-button bit masks in a valid-qualified data stream
// in bypass, level, one-shot or burst mode, and counts corrupted words.
module error_injector_multi #(
    parameter int                 W         = 8,
    parameter int                 N_BTN     = 2,
    parameter logic [N_BTN*W-1:0] MASKS     = {8'h10, 8'h01},
    parameter int                 BURST_LEN = 4,
    parameter int                 CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       mode,
    input  logic [N_BTN-1:0] btn,
    input  logic [W-1:0]     data_in,
    input  logic             valid_in,
    input  logic             clr_count,
    output logic [W-1:0]     data_out,
    output logic             valid_out,
    output logic             err_flag,
    output logic             armed,
    output logic [CNT_W-1:0] inj_count
);
    localparam int RW = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t           state_q, state_d;
    logic [N_BTN-1:0] s1_q, btn_s_q, btn_q, rise;
    logic [1:0]       mode_q;
    logic [W-1:0]     armed_mask_q, armed_mask_d, new_mask, lvl_mask, apply_mask;
    logic [RW-1:0]    rem_q, rem_d;
    logic [W-1:0]     data_q, data_d;
    logic             valid_q, err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_chg;

    assign rise     = btn_s_q & ~btn_q;
    assign mode_chg = mode != mode_q;

    always_comb begin
        new_mask = '0;
        lvl_mask = '0;
        for (int i = 0; i < N_BTN; i++) begin
            new_mask |= rise[i] ? MASKS[i*W +: W] : '0;
            lvl_mask |= btn_s_q[i] ? MASKS[i*W +: W] : '0;
        end
    end

    assign apply_mask = mode_chg ? '0 :
                        (mode == 2'b01) ? lvl_mask :
                        (mode[1] && state_q == ARMED) ? armed_mask_q : '0;

    // A rise while armed merges masks and reloads instead of consuming a word
    always_comb begin
        state_d      = state_q;
        armed_mask_d = armed_mask_q;
        rem_d        = rem_q;
        if (mode_chg) begin
            state_d      = IDLE;
            armed_mask_d = '0;
            rem_d        = '0;
        end else if (mode[1] && |rise) begin
            state_d      = ARMED;
            armed_mask_d = ((state_q == ARMED) ? armed_mask_q : '0) | new_mask;
            rem_d        = mode[0] ? RW'(BURST_LEN) : RW'(1);
        end else if (state_q == ARMED && valid_in) begin
            rem_d   = rem_q - RW'(1);
            state_d = (rem_q == RW'(1)) ? IDLE : ARMED;
        end
    end

    assign data_d = valid_in ? data_in ^ apply_mask : data_q;
    assign err_d  = valid_in ? |apply_mask : err_q;
    assign cnt_d  = clr_count ? '0 :
                    (valid_in && |apply_mask && ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q         <= '0;
            btn_s_q      <= '0;
            btn_q        <= '0;
            mode_q       <= '0;
            state_q      <= IDLE;
            armed_mask_q <= '0;
            rem_q        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            s1_q         <= btn;
            btn_s_q      <= s1_q;
            btn_q        <= btn_s_q;
            mode_q       <= mode;
            state_q      <= state_d;
            armed_mask_q <= armed_mask_d;
            rem_q        <= rem_d;
            data_q       <= data_d;
            valid_q      <= valid_in;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign err_flag  = err_q;
    assign armed     = state_q == ARMED;
    assign inj_count = cnt_q;
endmodule

// File: tb/tb_error_injector_multi.sv
// tb_error_injector_multi: directed scenarios plus random traffic against a behavioural
// model; a second instance with a 2-bit counter exercises saturation.
module tb_error_injector_multi;
    logic       clk = 1'b0, rstn = 1'b0;
    logic [1:0] mode = 2'b00, btn = 2'b00;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0, clr_count = 1'b0;
    logic [7:0] data_out, data_out2;
    logic       valid_out, valid_out2, err_flag, err_flag2, armed, armed2;
    logic [15:0] inj_count;
    logic [1:0]  inj_count2;

    int checks = 0, failures = 0;

    logic [1:0] hist[$];
    logic [1:0] m_mode;
    bit         m_armed;
    logic [7:0] m_mask;
    int         m_left;
    logic [7:0] e_dout;
    bit         e_vout, e_err;
    int         e_cnt, e_sat;

    always #5 clk = ~clk;

    error_injector_multi u_dut (
        .clk(clk), .rstn(rstn), .mode(mode), .btn(btn), .data_in(data_in),
        .valid_in(valid_in), .clr_count(clr_count), .data_out(data_out),
        .valid_out(valid_out), .err_flag(err_flag), .armed(armed), .inj_count(inj_count)
    );

    error_injector_multi #(.CNT_W(2)) u_sat (
        .clk(clk), .rstn(rstn), .mode(mode), .btn(btn), .data_in(data_in),
        .valid_in(valid_in), .clr_count(clr_count), .data_out(data_out2),
        .valid_out(valid_out2), .err_flag(err_flag2), .armed(armed2), .inj_count(inj_count2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] mask_of(input logic [1:0] b);
        return (b[0] ? 8'h01 : 8'h00) | (b[1] ? 8'h10 : 8'h00);
    endfunction

    task automatic model_reset();
        hist = '{2'b00, 2'b00, 2'b00};
        m_mode = 2'b00; m_armed = 0; m_mask = 8'h00; m_left = 0;
        e_dout = 8'h00; e_vout = 0; e_err = 0; e_cnt = 0; e_sat = 0;
    endtask

    // Predicts the outputs after the coming clock edge from the inputs now applied
    task automatic model_step();
        logic [1:0] bs, rise;
        logic [7:0] am;
        bit         chg;
        bs   = hist[1];
        rise = bs & ~hist[2];
        chg  = mode != m_mode;
        if (chg || mode == 2'b00) am = 8'h00;
        else if (mode == 2'b01)   am = mask_of(bs);
        else                      am = m_armed ? m_mask : 8'h00;
        e_vout = valid_in;
        if (valid_in) begin
            e_dout = data_in ^ am;
            e_err  = am != 0;
        end
        if (clr_count) begin
            e_cnt = 0; e_sat = 0;
        end else if (valid_in && am != 0) begin
            if (e_cnt < 65535) e_cnt++;
            if (e_sat < 3) e_sat++;
        end
        if (chg) begin
            m_armed = 0; m_mask = 8'h00;
        end else if (mode >= 2 && rise != 0) begin
            m_mask  = (m_armed ? m_mask : 8'h00) | mask_of(rise);
            m_left  = (mode == 2'b11) ? 4 : 1;
            m_armed = 1;
        end else if (m_armed && valid_in) begin
            m_left--;
            if (m_left == 0) m_armed = 0;
        end
        m_mode = mode;
        hist.push_front(btn);
        void'(hist.pop_back());
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_eq("data_out", data_out, e_dout);
        check_eq("valid_out", valid_out, e_vout);
        check_eq("err_flag", err_flag, e_err);
        check_eq("armed", armed, m_armed);
        check_eq("inj_count", inj_count, e_cnt);
        check_eq("data_out_sat", data_out2, e_dout);
        check_eq("inj_count_sat", inj_count2, e_sat);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic word(input logic [7:0] d);
        data_in = d; valid_in = 1'b1;
        cyc();
        valid_in = 1'b0;
    endtask

    task automatic press(input logic [1:0] b);
        btn = b; idle(4);
        btn = 2'b00; idle(3);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check_eq("rst_data_out", data_out, 8'h00);
        check_eq("rst_valid_out", valid_out, 1'b0);
        check_eq("rst_err_flag", err_flag, 1'b0);
        check_eq("rst_armed", armed, 1'b0);
        check_eq("rst_inj_count", inj_count, 16'h0);
        rstn = 1'b1;

        mode = 2'b01; btn = 2'b01; idle(3);
        word(8'hA5); check_eq("t1_lvl0", data_out, 8'hA4); check_eq("t1_err", err_flag, 1'b1);
        btn = 2'b11; idle(3);
        word(8'hA5); check_eq("t1_both", data_out, 8'hB4);
        btn = 2'b00; idle(3);
        word(8'hA5); check_eq("t1_rel", data_out, 8'hA5); check_eq("t1_rel_err", err_flag, 1'b0);

        clr_count = 1'b1; mode = 2'b10; idle(1); clr_count = 1'b0; idle(1);
        press(2'b10);
        check_eq("t2_armed", armed, 1'b1);
        word(8'h00); check_eq("t2_w0", data_out, 8'h10); check_eq("t2_disarm", armed, 1'b0);
        word(8'h00); check_eq("t2_w1", data_out, 8'h00);
        word(8'h00); check_eq("t2_w2", data_out, 8'h00);
        check_eq("t2_count", inj_count, 16'd1);

        mode = 2'b11; idle(2);
        press(2'b01);
        for (int i = 0; i < 6; i++) begin
            word(8'hFF);
            check_eq("t3_burst", data_out, (i < 4) ? 8'hFE : 8'hFF);
        end
        check_eq("t3_count", inj_count, 16'd5);

        press(2'b01);
        word(8'hFF); check_eq("t4_first", data_out, 8'hFE);
        idle(10);
        check_eq("t4_gap_armed", armed, 1'b1);
        check_eq("t4_gap_valid", valid_out, 1'b0);
        check_eq("t4_gap_hold", data_out, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            word(8'hFF); check_eq("t4_resume", data_out, 8'hFE);
        end
        word(8'hFF); check_eq("t4_done", data_out, 8'hFF);

        press(2'b10);
        mode = 2'b10;
        word(8'h00); check_eq("t5_modechg", data_out, 8'h00); check_eq("t5_disarm", armed, 1'b0);
        mode = 2'b11; idle(2);
        press(2'b01);
        word(8'h00); check_eq("t5_inburst", data_out, 8'h01);
        rstn = 1'b0;
        #2;
        check_eq("t5_rst_data", data_out, 8'h00);
        check_eq("t5_rst_err", err_flag, 1'b0);
        check_eq("t5_rst_armed", armed, 1'b0);
        check_eq("t5_rst_count", inj_count, 16'h0);
        model_reset();
        #1 rstn = 1'b1;
        idle(3);
        word(8'h00); check_eq("t5_clean", data_out, 8'h00);

        mode = 2'b01; btn = 2'b01; clr_count = 1'b1; idle(3); clr_count = 1'b0;
        repeat (5) word(8'h00);
        check_eq("t6_sat", inj_count2, 2'd3);
        check_eq("t6_wide", inj_count, 16'd5);
        clr_count = 1'b1; word(8'h00); clr_count = 1'b0;
        check_eq("t6_clr", inj_count2, 2'd0);
        btn = 2'b00;

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) btn = 2'($urandom);
            if ($urandom_range(0, 24) == 0) mode = 2'($urandom);
            valid_in  = $urandom_range(0, 9) < 7;
            data_in   = 8'($urandom);
            clr_count = $urandom_range(0, 39) == 0;
            cyc();
        end
        valid_in = 1'b0; clr_count = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
